// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Even op codes are the signed variants, the upper bit selects divide.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     acc, step_acc, sum, shifted, diff;
    logic [WIDTH-1:0]   work, step_work;
    logic [WIDTH-1:0]   a_q, b_mag_q, a_mag, b_mag;
    logic               is_div_q, neg_res_q, neg_rem_q, b_zero_q;
    logic               in_signed, accept, last_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign in_signed = is_signed_op(op);
    assign accept    = (state == MD_IDLE) && start && !cancel;
    assign last_step = (state == MD_BUSY) && !cancel && (cnt == CNT_W'(1));
    assign busy      = (state == MD_BUSY);
    assign valid     = (state == MD_DONE);

    md_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .value (a),
        .negate(in_signed & a[WIDTH-1]),
        .result(a_mag)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .value (b),
        .negate(in_signed & b[WIDTH-1]),
        .result(b_mag)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (start && !cancel) state_nx = MD_BUSY;
            MD_BUSY: begin
                if (cancel)                   state_nx = MD_IDLE;
                else if (cnt == CNT_W'(1))    state_nx = MD_DONE;
            end
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    // acc is the upper half ({acc, work} shifts as one 2W+1 register);
    // work holds the multiplier or the dividend/quotient bits.
    always_comb begin
        sum       = '0;
        shifted   = '0;
        diff      = '0;
        step_acc  = acc;
        step_work = work;
        if (is_div_q) begin
            shifted = {acc[WIDTH-1:0], work[WIDTH-1]};
            diff    = shifted - {1'b0, b_mag_q};
            // The partial remainder stays below the divisor, so the top bit of diff is the borrow.
            if (!diff[WIDTH]) begin
                step_acc  = diff;
                step_work = {work[WIDTH-2:0], 1'b1};
            end else begin
                step_acc  = shifted;
                step_work = {work[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum       = acc + (work[0] ? {1'b0, b_mag_q} : '0);
            step_acc  = {1'b0, sum[WIDTH:1]};
            step_work = {sum[0], work[WIDTH-1:1]};
        end
    end

    md_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value ({step_acc[WIDTH-1:0], step_work}),
        .negate(neg_res_q),
        .result(prod_fix)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value (step_work),
        .negate(neg_res_q),
        .result(quo_fix)
    );

    md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value (step_acc[WIDTH-1:0]),
        .negate(neg_rem_q),
        .result(rem_fix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
            acc       <= '0;
            work      <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_mag_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
        end else if (accept) begin
            acc       <= '0;
            work      <= a_mag;
            cnt       <= CNT_W'(WIDTH);
            a_q       <= a;
            b_mag_q   <= b_mag;
            is_div_q  <= is_div_op(op);
            neg_res_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= in_signed & a[WIDTH-1];
            b_zero_q  <= (b == '0);
        end else if ((state == MD_BUSY) && !cancel) begin
            acc  <= step_acc;
            work <= step_work;
            cnt  <= cnt - CNT_W'(1);
            if (last_step) begin
                if (!is_div_q) begin
                    {hi, lo} <= prod_fix;
                    div_zero <= 1'b0;
                end else if (b_zero_q) begin
                    hi       <= a_q;
                    lo       <= '1;
                    div_zero <= 1'b1;
                end else begin
                    hi       <= rem_fix;
                    lo       <= quo_fix;
                    div_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; companion to the single-cycle ALU in the EX stage.
- Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and produces a 2*WIDTH-bit result in hi/lo.
- Takes one radix-2 step per cycle. Reports busy/valid to the hazard unit so the pipeline can stall.
- Supports abort on exception flush.

Parameters:
- WIDTH, 32, operand width in bits (>= 4). hi/lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, localparam, iteration counter width.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- cancel  in  1  abort in-flight operation (exception flush).
- busy  out  1  operation in progress.
- valid  out  1  one-cycle pulse: hi/lo/div_zero carry a new result.
- hi  out  WIDTH  MULT: product upper half. DIV: remainder.
- lo  out  WIDTH  MULT: product lower half. DIV: quotient.
- div_zero  out  1  last division had b == 0; updated with valid.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy=0, valid=0, hi=0, lo=0, div_zero=0. rst has priority over cancel and start.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY when start=1 and cancel=0 at an edge. On that edge, a, b and op are latched, the operands are converted to magnitudes for signed ops, and the counter is loaded with WIDTH. The input ports may change freely afterwards.
- start in BUSY or DONE is ignored and has no queueing.
- BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; the counter decrements each step. After WIDTH steps -> DONE.
- At the BUSY -> DONE edge: sign correction is applied and hi/lo/div_zero are registered.
- DONE: valid=1 for exactly one cycle, busy=0. Next edge -> IDLE.
- Latency: start sampled at edge E0; valid is high in the cycle after edge E(WIDTH), i.e. results are visible WIDTH+1 cycles after E0.
- busy is 1 exactly in BUSY. The hazard unit stalls on busy.
- hi/lo hold their value between results. They change only at the BUSY -> DONE edge or at reset.
- Signed multiply: multiply the magnitudes, then negate the 2W-bit product if a[W-1]^b[W-1].
- Signed divide: divide the magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: a = lo*b + hi.
- Divide by zero (b == 0, DIV or DIVU): still takes the full latency. Result is div_zero=1, hi=a as latched, lo=all ones.
- div_zero=0 for every multiply and for every non-zero divide.
- Signed overflow case, a = most negative value and b = -1: lo = most negative value, hi = 0, div_zero = 0.
- cancel=1 in BUSY or DONE: state -> IDLE at the next edge. valid is forced 0 in the following cycle, and hi/lo/div_zero keep their prior values.
- cancel=1 in IDLE: start is ignored on that edge.
- Magnitude of the most negative value is handled as an unsigned WIDTH-bit value.
- The multiply accumulator and the divide partial remainder are WIDTH+1 bits wide internally; no internal truncation.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state encoding MD_IDLE, MD_BUSY, MD_DONE.
- One combinational sub-module, md_sign_fix: conditional two's-complement negate, parametrised by width. It is instantiated for operand magnitude (WIDTH bits) and for result correction (2*WIDTH and WIDTH bits).
- FSM, counter and datapath stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> valid exactly 33 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001, busy high for 32 cycles.
- MULT a=0xFFFFFFFD (-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Operands are changed on the cycle after start, and the result must be unaffected.
- DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0. DIVU with the same inputs -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=7 b=0 -> div_zero=1, hi=0x00000007, lo=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start a MULT, then assert cancel in BUSY cycle 10 -> busy=0 next cycle, no valid pulse, hi/lo equal the previous result. start+cancel together in IDLE -> stays IDLE. rst mid-operation -> all outputs 0 the next cycle.
- Random signed/unsigned ops with WIDTH=8 and WIDTH=32, compared against a reference model. Back-to-back starts issued in the DONE cycle must be ignored, and the next start in IDLE must be accepted.
